// File: rtl/gb_lock_pkg.sv
// Shared definitions for the 22-bit gearbox word-lock block: sync header
// codes, lock FSM state encoding, default thresholds and a header check.
package gb_lock_pkg;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    localparam int GOOD_TO_LOCK_DEF  = 64;
    localparam int BAD_WINDOW_DEF    = 64;
    localparam int BAD_TO_UNLOCK_DEF = 16;
    localparam int SLIP_WAIT_DEF     = 24;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        SLIP   = 2'b01,
        WAIT   = 2'b10,
        LOCKED = 2'b11
    } lock_state_t;

    // A sync header is legal only when its two bits differ.
    function automatic logic hdr_ok(input logic [1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

endpackage

// File: rtl/gb_lock_sat_cnt.sv
// Saturating up-counter with synchronous clear (priority) and a qualified
// increment. Width is sized to hold MAX exactly.
module gb_lock_sat_cnt
    import gb_lock_pkg::*;
#(
    parameter int MAX = 64
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       inc,
    output logic [$clog2(MAX+1)-1:0]   cnt
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_r;

    // Count register: clear wins, otherwise step up until MAX and stick.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (en && inc && (cnt_r != MAX_V)) begin
            cnt_r <= cnt_r + W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/gearbox_22_lock.sv
// Word-boundary lock for the 20-to-22 gearbox output. Hunts for a run of
// legal sync headers, slipping the gearbox one bit at a time (odd toggle,
// plus a 2-bit drop on every second slip) until it locks, then forwards the
// payload and watches the header error rate in a sliding window.
// Optional build macro GB_LOCK_STATS_EN adds hdr_err_cnt and slip_cnt.
module gearbox_22_lock
    import gb_lock_pkg::*;
#(
    parameter int GOOD_TO_LOCK  = GOOD_TO_LOCK_DEF,
    parameter int BAD_WINDOW    = BAD_WINDOW_DEF,
    parameter int BAD_TO_UNLOCK = BAD_TO_UNLOCK_DEF,
    parameter int SLIP_WAIT     = SLIP_WAIT_DEF
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [21:0] din,
    input  logic        din_valid,
    output logic        odd,
    output logic        drop2,
    output logic [19:0] dout,
    output logic        dout_ctrl,
    output logic        dout_valid,
    output logic        locked
`ifdef GB_LOCK_STATS_EN
    ,
    output logic [15:0] hdr_err_cnt,
    output logic [7:0]  slip_cnt
`endif
);

    localparam int GW = $clog2(GOOD_TO_LOCK + 1);
    localparam int WW = $clog2(BAD_WINDOW + 1);
    localparam int BW = $clog2(BAD_TO_UNLOCK + 1);
    localparam int SW = $clog2(SLIP_WAIT + 1);

    // Compare against threshold-1 so the word that reaches a threshold acts
    // on the same edge it is counted.
    localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_TO_LOCK - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(BAD_WINDOW - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(BAD_TO_UNLOCK - 1);
    localparam logic [SW-1:0] WAIT_LAST = SW'(SLIP_WAIT - 1);

    lock_state_t state_r;
    lock_state_t state_s;

    logic          hdr_good_s;
    logic [GW-1:0] good_cnt_r;
    logic [WW-1:0] win_cnt_r;
    logic [BW-1:0] bad_cnt_r;
    logic [SW-1:0] wait_cnt_r;
    logic good_clr_s, good_inc_s;
    logic win_clr_s,  win_inc_s;
    logic bad_clr_s,  bad_inc_s;
    logic wait_clr_s, wait_inc_s;

    logic        odd_r;
    logic        drop2_r;
    logic [19:0] dout_r;
    logic        dout_ctrl_r;
    logic        dout_valid_r;
    logic        locked_r;

    assign hdr_good_s = hdr_ok(din[1:0]);

    gb_lock_sat_cnt #(.MAX(GOOD_TO_LOCK)) u_good_cnt (
        .clk(clk), .arst_n(arst_n), .en(din_valid),
        .clr(good_clr_s), .inc(good_inc_s), .cnt(good_cnt_r)
    );

    gb_lock_sat_cnt #(.MAX(BAD_WINDOW)) u_win_cnt (
        .clk(clk), .arst_n(arst_n), .en(din_valid),
        .clr(win_clr_s), .inc(win_inc_s), .cnt(win_cnt_r)
    );

    gb_lock_sat_cnt #(.MAX(BAD_TO_UNLOCK)) u_bad_cnt (
        .clk(clk), .arst_n(arst_n), .en(din_valid),
        .clr(bad_clr_s), .inc(bad_inc_s), .cnt(bad_cnt_r)
    );

    gb_lock_sat_cnt #(.MAX(SLIP_WAIT)) u_wait_cnt (
        .clk(clk), .arst_n(arst_n), .en(din_valid),
        .clr(wait_clr_s), .inc(wait_inc_s), .cnt(wait_cnt_r)
    );

    // Lock FSM state register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and counter controls; counters owned by other states are
    // held clear so every state is entered with fresh counts.
    always_comb begin
        state_s    = state_r;
        good_clr_s = 1'b0;
        good_inc_s = 1'b0;
        win_clr_s  = 1'b0;
        win_inc_s  = 1'b0;
        bad_clr_s  = 1'b0;
        bad_inc_s  = 1'b0;
        wait_clr_s = 1'b0;
        wait_inc_s = 1'b0;
        case (state_r)
            HUNT: begin
                win_clr_s  = 1'b1;
                bad_clr_s  = 1'b1;
                wait_clr_s = 1'b1;
                if (din_valid) begin
                    if (hdr_good_s) begin
                        good_inc_s = 1'b1;
                        if (good_cnt_r == GOOD_LAST) begin
                            state_s = LOCKED;
                        end else begin
                            state_s = HUNT;
                        end
                    end else begin
                        good_clr_s = 1'b1;
                        state_s    = SLIP;
                    end
                end else begin
                    state_s = HUNT;
                end
            end
            SLIP: begin
                // Single clock, taken whether or not a word is present.
                good_clr_s = 1'b1;
                win_clr_s  = 1'b1;
                bad_clr_s  = 1'b1;
                wait_clr_s = 1'b1;
                state_s    = WAIT;
            end
            WAIT: begin
                good_clr_s = 1'b1;
                win_clr_s  = 1'b1;
                bad_clr_s  = 1'b1;
                if (din_valid) begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        wait_clr_s = 1'b1;
                        state_s    = HUNT;
                    end else begin
                        wait_inc_s = 1'b1;
                        state_s    = WAIT;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            LOCKED: begin
                good_clr_s = 1'b1;
                wait_clr_s = 1'b1;
                if (din_valid) begin
                    if (!hdr_good_s && (bad_cnt_r == BAD_LAST)) begin
                        // Unlock takes precedence over a coinciding window end.
                        win_clr_s = 1'b1;
                        bad_clr_s = 1'b1;
                        state_s   = SLIP;
                    end else if (win_cnt_r == WIN_LAST) begin
                        win_clr_s = 1'b1;
                        bad_clr_s = 1'b1;
                        state_s   = LOCKED;
                    end else begin
                        win_inc_s = 1'b1;
                        bad_inc_s = !hdr_good_s;
                        state_s   = LOCKED;
                    end
                end else begin
                    state_s = LOCKED;
                end
            end
            default: begin
                good_clr_s = 1'b1;
                win_clr_s  = 1'b1;
                bad_clr_s  = 1'b1;
                wait_clr_s = 1'b1;
                state_s    = HUNT;
            end
        endcase
    end

    // Registered outputs: slip controls move only when leaving SLIP, lock
    // tracks the next state, payload is captured for every locked word.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            odd_r        <= 1'b0;
            drop2_r      <= 1'b0;
            dout_r       <= 20'h00000;
            dout_ctrl_r  <= 1'b0;
            dout_valid_r <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            if (state_r == SLIP) begin
                // odd 0->1 is a 1-bit shift; odd 1->0 plus drop2 is net +1 too.
                odd_r   <= ~odd_r;
                drop2_r <= odd_r;
            end else begin
                odd_r   <= odd_r;
                drop2_r <= 1'b0;
            end
            locked_r <= (state_s == LOCKED);
            if ((state_r == LOCKED) && din_valid) begin
                dout_r       <= din[21:2];
                dout_ctrl_r  <= !hdr_good_s || (din[1:0] == HDR_CTRL);
                dout_valid_r <= 1'b1;
            end else begin
                dout_r       <= dout_r;
                dout_ctrl_r  <= dout_ctrl_r;
                dout_valid_r <= 1'b0;
            end
        end
    end

    assign odd        = odd_r;
    assign drop2      = drop2_r;
    assign dout       = dout_r;
    assign dout_ctrl  = dout_ctrl_r;
    assign dout_valid = dout_valid_r;
    assign locked     = locked_r;

`ifdef GB_LOCK_STATS_EN
    logic hdr_err_inc_s;
    logic slip_inc_s;

    assign hdr_err_inc_s = (state_r == LOCKED) && din_valid && !hdr_good_s;
    assign slip_inc_s    = (state_r != SLIP) && (state_s == SLIP);

    gb_lock_sat_cnt #(.MAX(65535)) u_hdr_err_cnt (
        .clk(clk), .arst_n(arst_n), .en(1'b1),
        .clr(1'b0), .inc(hdr_err_inc_s), .cnt(hdr_err_cnt)
    );

    gb_lock_sat_cnt #(.MAX(255)) u_slip_cnt (
        .clk(clk), .arst_n(arst_n), .en(1'b1),
        .clr(1'b0), .inc(slip_inc_s), .cnt(slip_cnt)
    );
`endif

endmodule

// File: tb/tb_gearbox_22_lock.sv
// Directed bench for gearbox_22_lock: aligned lock, header-error windows,
// slip walk on garbage, misaligned stream through a gearbox shift model,
// and asynchronous reset in the middle of a slip.
module tb_gearbox_22_lock;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [21:0] din = 22'h000000;
    logic        din_valid = 1'b0;
    logic        odd;
    logic        drop2;
    logic [19:0] dout;
    logic        dout_ctrl;
    logic        dout_valid;
    logic        locked;
`ifdef GB_LOCK_STATS_EN
    logic [15:0] hdr_err_cnt;
    logic [7:0]  slip_cnt;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_drop2 = 0;
    int   n_tog = 0;
    logic odd_prev = 1'b0;

    gearbox_22_lock dut (
        .clk(clk), .arst_n(arst_n), .din(din), .din_valid(din_valid),
        .odd(odd), .drop2(drop2), .dout(dout), .dout_ctrl(dout_ctrl),
        .dout_valid(dout_valid), .locked(locked)
`ifdef GB_LOCK_STATS_EN
        , .hdr_err_cnt(hdr_err_cnt), .slip_cnt(slip_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (drop2 === 1'b1) n_drop2++;
        if (odd !== odd_prev) n_tog++;
        odd_prev = odd;
    endtask

    task automatic send(input logic [21:0] w, input logic v);
        din = w;
        din_valid = v;
        tick();
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        din_valid = 1'b0;
        din = 22'h000000;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        odd_prev = 1'b0;
        n_drop2 = 0;
        n_tog = 0;
    endtask

    // Pseudo-random payload for word k with the given header.
    function automatic logic [21:0] tx_word(input int k, input logic [1:0] hdr);
        logic [31:0] x;
        x = k * 32'h9E3779B1;
        x = x ^ (x >> 15);
        x = x * 32'h85EBCA6B;
        x = x ^ (x >> 13);
        return {x[19:0], hdr};
    endfunction

    // Receiver word j of an all-data stream when the gearbox window is
    // advanced by s bits.
    function automatic logic [21:0] rx_word(input int j, input int s);
        logic [21:0] r;
        logic [21:0] w;
        int b;
        for (int i = 0; i < 22; i++) begin
            b = 22 * j + s + i;
            w = tx_word(b / 22, 2'b01);
            r[i] = w[b % 22];
        end
        return r;
    endfunction

    task automatic lock_up(input string tag);
        do_reset();
        for (int k = 0; k < 64; k++) send(tx_word(1000 + k, 2'b01), 1'b1);
        chk(tag, locked, 1'b1);
    endtask

    initial begin
        logic [21:0] w;
        logic [19:0] last_pay;
        logic [1:0]  h;
        int k;
        int j;
        int wk;

        // Reset values.
        #1;
        chk("rst_odd", odd, 1'b0);
        chk("rst_drop2", drop2, 1'b0);
        chk("rst_dout", dout, 20'h00000);
        chk("rst_dout_ctrl", dout_ctrl, 1'b0);
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_locked", locked, 1'b0);
`ifdef GB_LOCK_STATS_EN
        chk("rst_hdr_err", hdr_err_cnt, 16'h0000);
        chk("rst_slip", slip_cnt, 8'h00);
`endif

        // Aligned stream with idle gaps carrying an illegal header.
        do_reset();
        k = 0;
        last_pay = 20'h00000;
        for (int c = 0; k < 200; c++) begin
            if ((c % 7) != 3) begin
                w = tx_word(k, 2'b01);
                send(w, 1'b1);
                chk("al_locked", locked, (k >= 63));
                chk("al_dvalid", dout_valid, (k >= 64));
                if (k >= 64) begin
                    chk("al_dout", dout, w[21:2]);
                    chk("al_dctrl", dout_ctrl, 1'b0);
                    last_pay = w[21:2];
                end
                k++;
            end else begin
                send(22'h000000, 1'b0);
                chk("al_gap_dvalid", dout_valid, 1'b0);
                chk("al_gap_locked", locked, (k >= 64));
                if (k >= 65) chk("al_gap_hold", dout, last_pay);
            end
        end
        chk("al_drop2s", n_drop2, 0);
        chk("al_toggles", n_tog, 0);

        // 15 errors in one window keep lock; 16 in the next drop it.
        lock_up("e15_lock");
        wk = 0;
        for (int i = 0; i < 64; i++) begin
            h = (i < 15) ? (((i % 2) == 1) ? 2'b11 : 2'b00) : 2'b01;
            w = tx_word(wk, h);
            wk++;
            send(w, 1'b1);
            chk("e15_locked", locked, 1'b1);
            if (i == 0) begin
                chk("e15_err_dout", dout, w[21:2]);
                chk("e15_err_ctrl", dout_ctrl, 1'b1);
                chk("e15_err_dvalid", dout_valid, 1'b1);
            end
        end
`ifdef GB_LOCK_STATS_EN
        chk("e15_hdr_err", hdr_err_cnt, 16'd15);
`endif
        for (int i = 0; i < 16; i++) begin
            send(tx_word(wk, 2'b00), 1'b1);
            wk++;
            chk("e16_locked", locked, (i < 15));
        end
        send(tx_word(wk, 2'b01), 1'b1);
        chk("e16_slip_odd", odd, 1'b1);
        chk("e16_slip_drop2", drop2, 1'b0);
        chk("e16_dvalid", dout_valid, 1'b0);
`ifdef GB_LOCK_STATS_EN
        chk("e16_hdr_err", hdr_err_cnt, 16'd31);
        chk("e16_slip", slip_cnt, 8'd1);
`endif

        // 15 errors at end of one window, 15 at start of the next.
        lock_up("ww_lock");
        for (int i = 0; i < 128; i++) begin
            if (i < 49) h = (i == 0) ? 2'b10 : 2'b01;
            else if (i < 79) h = 2'b00;
            else h = 2'b01;
            send(tx_word(i, h), 1'b1);
            if (i == 0) chk("ww_ctrl_hdr", dout_ctrl, 1'b1);
            if (i == 1) chk("ww_data_hdr", dout_ctrl, 1'b0);
            chk("ww_locked", locked, 1'b1);
        end
`ifdef GB_LOCK_STATS_EN
        chk("ww_hdr_err", hdr_err_cnt, 16'd30);
`endif

        // 16th error on the last word of a window: unlock wins.
        lock_up("co_lock");
        for (int i = 0; i < 64; i++) begin
            send(tx_word(i, (i < 48) ? 2'b01 : 2'b11), 1'b1);
            chk("co_locked", locked, (i < 63));
        end

        // Continuous garbage: 22 slips walk all offsets back to odd=0.
        do_reset();
        for (int t = 0; t < 572; t++) begin
            send({20'hABCDE, 2'b00}, 1'b1);
            chk("gb_locked", locked, 1'b0);
        end
        chk("gb_toggles", n_tog, 22);
        chk("gb_drop2s", n_drop2, 11);
        chk("gb_odd", odd, 1'b0);
`ifdef GB_LOCK_STATS_EN
        chk("gb_slip", slip_cnt, 8'd22);
`endif
        send({20'hABCDE, 2'b00}, 1'b1);
        send({20'hABCDE, 2'b00}, 1'b1);
        chk("gb_repeat_odd", odd, 1'b1);
        chk("gb_repeat_tog", n_tog, 23);

        // Stream 7 slips short of alignment: window starts 15 bits in.
        do_reset();
        j = 0;
        for (int t = 0; (t < 4000) && (locked !== 1'b1); t++) begin
            send(rx_word(j, 15 + int'(odd) + 2 * n_drop2), 1'b1);
            j++;
        end
        chk("mis_locked", locked, 1'b1);
        chk("mis_toggles", n_tog, 7);
        chk("mis_drop2s", n_drop2, 3);
        chk("mis_odd", odd, 1'b1);
`ifdef GB_LOCK_STATS_EN
        chk("mis_slip", slip_cnt, 8'd7);
`endif
        send(rx_word(j, 22), 1'b1);
        w = tx_word(j + 1, 2'b01);
        chk("mis_dout", dout, w[21:2]);
        chk("mis_dvalid", dout_valid, 1'b1);

        // Reset asserted during a slip that would pulse drop2.
        do_reset();
        for (int i = 0; i < 27; i++) send({20'h12345, 2'b11}, 1'b1);
        chk("rs_pre_odd", odd, 1'b1);
        chk("rs_pre_tog", n_tog, 1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("rs_odd", odd, 1'b0);
        chk("rs_drop2", drop2, 1'b0);
        chk("rs_locked", locked, 1'b0);
        chk("rs_dvalid", dout_valid, 1'b0);
        chk("rs_dout", dout, 20'h00000);
        chk("rs_dctrl", dout_ctrl, 1'b0);
        @(posedge clk);
        #1;
        chk("rs_no_glitch", drop2, 1'b0);
        arst_n = 1'b1;
        odd_prev = 1'b0;
        n_drop2 = 0;
        n_tog = 0;
        for (int i = 0; i < 64; i++) begin
            send(tx_word(500 + i, 2'b01), 1'b1);
            chk("rs_relock", locked, (i == 63));
        end
        chk("rs_relock_drop2", n_drop2, 0);
        chk("rs_relock_odd", odd, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
